y86_bus_tracer: RTL and testbench

Y86_BUS_TRACER -- requirements
Module: y86_bus_tracer

---
 rtl/y86_bus_tracer_pkg.sv | 52 +++++
 rtl/y86_trace_fifo.sv | 63 ++++++
 rtl/y86_bus_tracer.sv | 155 +++++++++++++++
 tb/tb_y86_bus_tracer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_bus_tracer_pkg.sv
// Shared types for the Y86 bus tracer: record layout, kind codes, serializer
// states and trace-header field positions.
package y86_trace_pkg;

    localparam logic [1:0] KIND_RD  = 2'b01;
    localparam logic [1:0] KIND_WR  = 2'b10;
    localparam logic [1:0] KIND_ERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam int REC_W        = 74;
    localparam int HDR_OPC_LSB  = 24;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_DROP_LSB = 8;
    localparam int HDR_KIND_LSB = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    // seq and drop_cnt are stamped at push time, so they travel with the record.
    typedef struct packed {
        logic [7:0] seq;
        logic [7:0] drop_cnt;
        rec_t       rec;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [31:0] make_hdr(input entry_t e);
        logic [31:0] w;
        w = '0;
        w[HDR_OPC_LSB  +: 8] = e.rec.opcode;
        w[HDR_SEQ_LSB  +: 8] = e.seq;
        w[HDR_DROP_LSB +: 8] = e.drop_cnt;
        w[HDR_KIND_LSB +: 2] = e.rec.kind;
        return w;
    endfunction

    function automatic logic [1:0] kind_of(input logic re, input logic we);
        return {we, re};
    endfunction

endpackage

// File: rtl/y86_trace_fifo.sv
// Record FIFO for the bus tracer; a push into a full FIFO succeeds only when
// a pop happens in the same cycle.
module y86_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/y86_bus_tracer.sv
// Captures Y86 bus read/write cycles into records and serializes each record
// as three trace words (header, address, data) over a valid/ready stream.
module y86_bus_tracer
    import y86_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [31:0]  bus_A,
    input  logic [31:0]  bus_in,
    input  logic [31:0]  bus_out,
    input  logic         bus_RE,
    input  logic         bus_WE,
    input  logic [7:0]   current_opcode,
    output logic         trace_valid,
    input  logic         trace_ready,
    output logic [31:0]  trace_data,
    output logic         trace_last,
    output logic [6:0]   fifo_level,
    output logic         overflow,
    output state_t       dbg_state
);

    // Stream handshake: a word transfers on any cycle with trace_valid && trace_ready;
    // once trace_valid rises, trace_valid and trace_data hold until that transfer.

    state_t      state_q, state_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  drop_q, drop_d;
    logic        ovf_q, ovf_d;

    logic        capture, accept, load, push_en, drop_now;
    logic        fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_lvl;
    entry_t      fifo_wr, fifo_rd;

    assign capture = enable && (bus_RE || bus_WE);
    assign accept  = valid_q && trace_ready;
    assign load    = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_DATA && accept));
    assign push_en  = capture && (!fifo_full || load);
    assign drop_now = capture && fifo_full && !load;

    always_comb begin
        fifo_wr.seq        = seq_q;
        fifo_wr.drop_cnt   = drop_q;
        fifo_wr.rec.kind   = kind_of(bus_RE, bus_WE);
        fifo_wr.rec.opcode = current_opcode;
        fifo_wr.rec.addr   = bus_A;
        fifo_wr.rec.data   = bus_WE ? bus_out : bus_in;
    end

    y86_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_en),
        .wr_data (fifo_wr),
        .pop     (load),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (push_en) begin
            seq_d  = seq_q + 8'd1;
            drop_d = 8'd0;
        end else if (drop_now) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_HDR:  if (accept) begin
                state_d = ST_ADDR;
                data_d  = hold_addr_q;
            end
            ST_ADDR: if (accept) begin
                state_d = ST_DATA;
                data_d  = hold_data_q;
                last_d  = 1'b1;
            end
            ST_DATA: if (accept) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        // A pop from IDLE or on the final word starts the next header without a bubble.
        if (load) begin
            state_d     = ST_HDR;
            hold_addr_d = fifo_rd.rec.addr;
            hold_data_d = fifo_rd.rec.data;
            valid_d     = 1'b1;
            data_d      = make_hdr(fifo_rd);
            last_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            seq_q       <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
        end
    end

    assign trace_valid = valid_q;
    assign trace_data  = data_q;
    assign trace_last  = last_q;
    assign overflow    = ovf_q;
    assign fifo_level  = 7'(fifo_lvl);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_y86_bus_tracer.sv
// Bench for y86_bus_tracer: directed scenarios plus random traffic, checked by
// a record-level reference model feeding an expected-word queue.
module tb_y86_bus_tracer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] bus_A, bus_in, bus_out;
    logic        bus_RE, bus_WE;
    logic [7:0]  current_opcode;
    logic        trace_valid, trace_ready, trace_last, overflow;
    logic [31:0] trace_data;
    logic [6:0]  fifo_level;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected words: {last, data}
    logic [32:0] exp_q[$];

    // Reference model: record counts and word progress only.
    int m_busy  = 0;
    int m_left  = 0;
    int m_level = 0;
    int m_seq   = 0;
    int m_drop  = 0;
    int m_ovf   = 0;

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    y86_bus_tracer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .bus_A          (bus_A),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .bus_RE         (bus_RE),
        .bus_WE         (bus_WE),
        .current_opcode (current_opcode),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_last     (trace_last),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: compare cycle-level observables, then apply this cycle's inputs.
    always @(negedge clk) begin
        bit pop;
        bit cap;
        logic [31:0] hdr;
        check("valid", trace_valid, 32'(m_busy));
        check("level", 32'(fifo_level), 32'(m_level));
        check("overflow", overflow, 32'(m_ovf));
        if (m_busy == 0) begin
            check("idle_data", trace_data, 32'h0);
            check("idle_last", trace_last, 32'h0);
        end
        if (rst) begin
            m_busy = 0; m_left = 0; m_level = 0;
            m_seq = 0; m_drop = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            pop = 1'b0;
            if (m_busy == 0) pop = (m_level > 0);
            else if (trace_ready && m_left == 1) pop = (m_level > 0);
            cap = enable && (bus_RE || bus_WE);
            if (cap) begin
                if (m_level < DEPTH || pop) begin
                    hdr = {current_opcode, 8'(m_seq), 8'(m_drop), 6'b0, bus_WE, bus_RE};
                    exp_q.push_back({1'b0, hdr});
                    exp_q.push_back({1'b0, bus_A});
                    exp_q.push_back({1'b1, bus_WE ? bus_out : bus_in});
                    m_seq = (m_seq + 1) % 256;
                    m_drop = 0;
                    m_level++;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end
            end
            if (pop) m_level--;
            if (m_busy == 0) begin
                if (pop) begin m_busy = 1; m_left = 3; end
            end else if (trace_ready) begin
                m_left--;
                if (m_left == 0) begin
                    if (pop) m_left = 3;
                    else m_busy = 0;
                end
            end
        end
    end

    // Monitor: every accepted word is popped from the expected queue.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", trace_valid, 32'h1);
                check("stall_data", trace_data, prev_data);
            end
            if (trace_valid && trace_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h expected=none", trace_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", trace_data, e[31:0]);
                    check("word_last", trace_last, 32'(e[32]));
                end
            end
            prev_stall = trace_valid && !trace_ready;
            prev_data  = trace_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
    endtask

    task automatic cap(input logic re, input logic we, input logic [31:0] a,
                       input logic [31:0] din, input logic [31:0] dout, input logic [7:0] op);
        enable = 1'b1; bus_RE = re; bus_WE = we;
        bus_A = a; bus_in = din; bus_out = dout; current_opcode = op;
    endtask

    task automatic no_cap();
        enable = 1'b0; bus_RE = 1'b0; bus_WE = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        trace_ready = 1'b1;
        no_cap();
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 words left", exp_q.size());
        end
        tick();
    endtask

    initial begin
        logic [1:0] sel;
        rst = 1'b1; trace_ready = 1'b0;
        bus_A = '0; bus_in = '0; bus_out = '0; current_opcode = '0;
        no_cap();
        tick(); tick();
        at_mid();
        check("rst_valid", trace_valid, 32'h0);
        check("rst_data", trace_data, 32'h0);
        check("rst_last", trace_last, 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_overflow", overflow, 32'h0);
        tick();
        rst = 1'b0;

        // Read: header/addr/data in cycles N+2..N+4.
        trace_ready = 1'b1;
        cap(1'b1, 1'b0, 32'h10, 32'h000045E8, 32'h0, 8'h89);
        tick(); no_cap();
        tick(); at_mid();
        check("rd_hdr_valid", trace_valid, 32'h1);
        check("rd_hdr", trace_data, 32'h89000001);
        tick(); at_mid();
        check("rd_addr", trace_data, 32'h00000010);
        tick(); at_mid();
        check("rd_data", trace_data, 32'h000045E8);
        check("rd_last", trace_last, 32'h1);
        tick();

        // Write with downstream stalled for several cycles.
        trace_ready = 1'b0;
        cap(1'b0, 1'b1, 32'h20, 32'h0, 32'hDEADBEEF, 8'h40);
        tick(); no_cap();
        repeat (5) tick();
        at_mid();
        check("wr_hdr_held", trace_data, 32'h40010002);
        trace_ready = 1'b1;
        repeat (5) tick();

        // Both strobes: protocol-error kind.
        cap(1'b1, 1'b1, 32'h30, 32'h1111, 32'h2222, 8'h55);
        tick(); no_cap();
        tick(); at_mid();
        check("err_hdr", trace_data, 32'h55020003);
        drain();

        // Overflow: 11 captures while stalled.
        trace_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cap(1'b1, 1'b0, $urandom, $urandom, $urandom, 8'($urandom));
            tick();
        end
        no_cap();
        at_mid();
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", overflow, 32'h1);
        trace_ready = 1'b1;
        repeat (3) tick();
        cap(1'b0, 1'b1, 32'h44, 32'h0, 32'h5555AAAA, 8'h61);
        tick();
        drain();

        // Reset in the middle of the ADDR word with three records queued.
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cap(1'b1, 1'b0, 32'h100 + 32'(i), $urandom, 32'h0, 8'h70);
            tick();
        end
        no_cap();
        tick();
        at_mid();
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        tick();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_mid();
        check("post_rst_valid", trace_valid, 32'h0);
        check("post_rst_level", 32'(fifo_level), 32'h0);
        check("post_rst_ovf", overflow, 32'h0);
        tick();
        trace_ready = 1'b1;
        cap(1'b1, 1'b0, 32'h200, 32'h0BADF00D, 32'h0, 8'h12);
        tick(); no_cap();
        tick(); at_mid();
        check("post_rst_hdr", trace_data, 32'h12000001);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 7) != 0);
            bus_RE = sel[0];
            bus_WE = sel[1];
            bus_A = $urandom; bus_in = $urandom; bus_out = $urandom;
            current_opcode = 8'($urandom);
            trace_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // 260 spaced captures: seq wraps, nothing dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            cap(1'b0, 1'b1, $urandom, 32'h0, $urandom, 8'($urandom));
            tick(); no_cap();
            tick(); tick();
        end
        drain();
        at_mid();
        check("wrap_overflow", overflow, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
